// File: rtl/cpu65_pkg.sv
// Shared types and constants for the 65C02 address-generation logic.
// No timing of its own.
// No flow control of its own.
package cpu65_pkg;

  // Addressing modes as encoded on the mode input; RSVD behaves as ABS.
  typedef enum logic [2:0] {
    ZPX  = 3'd0,
    ZPY  = 3'd1,
    ABSX = 3'd2,
    ABSY = 3'd3,
    INDX = 3'd4,
    INDY = 3'd5,
    ABS  = 3'd6,
    RSVD = 3'd7
  } addr_mode_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    OPLO = 3'd1,
    OPHI = 3'd2,
    PLO  = 3'd3,
    PHI  = 3'd4,
    FIX  = 3'd5,
    DONE = 3'd6
  } agen_state_e;

  localparam logic [7:0] ZP_PAGE = 8'h00;

  // Index register that participates in a given mode (0 for plain absolute).
  function automatic logic [7:0] index_sel(input addr_mode_e m,
                                           input logic [7:0] x,
                                           input logic [7:0] y);
    logic [7:0] r;
    r = 8'h00;
    case (m)
      ZPX, ABSX, INDX: r = x;
      ZPY, ABSY, INDY: r = y;
      default:         r = 8'h00;
    endcase
    return r;
  endfunction

  // Modes whose store/RMW timing always spends the fix-up cycle when asked.
  function automatic logic is_indexed_abs(input addr_mode_e m);
    return (m == ABSX) || (m == ABSY) || (m == INDY);
  endfunction

endpackage

// File: rtl/index_adder.sv
// 8-bit base plus 8-bit index with carry out, for low-byte address formation.
// Purely combinational, zero cycles.
// No flow control.
module index_adder (
  input  logic [7:0] base,
  input  logic [7:0] index,
  output logic [7:0] sum,
  output logic       carry
);

  // Carry is the page-cross indication for the caller.
  always_comb begin
    {carry, sum} = {1'b0, base} + {1'b0, index};
  end

endmodule

// File: rtl/indexed_address_gen.sv
// Effective-address generator for indexed / indirect 65C02 addressing modes.
// Latency start->addr_valid: ZP 2, ABS 3 (4 with fix), INDX 4, INDY 4 (5 with fix).
// Stalls in OPLO/OPHI/PLO/PHI until db_valid; start ignored while busy.
module indexed_address_gen
  import cpu65_pkg::*;
#(
  parameter logic [7:0] ZP_BASE = ZP_PAGE
) (
  input  logic        clk,
  input  logic        resb,
  input  logic        start,
  input  logic [2:0]  mode,
  input  logic        always_fix,
  input  logic [7:0]  x_index,
  input  logic [7:0]  y_index,
  input  logic [7:0]  db_in,
  input  logic        db_valid,
  output logic        ptr_req,
  output logic [15:0] ptr_addr,
  output logic        busy,
  output logic [15:0] addr_out,
  output logic        addr_valid,
  output logic        page_cross
);

  agen_state_e state_q, state_d;
  addr_mode_e  mode_q, mode_d;
  logic [7:0]  idx_q, idx_d;
  logic [7:0]  lo_q, lo_d;
  logic [7:0]  ptr_q, ptr_d;
  logic [15:0] addr_q, addr_d;
  logic        carry_q, carry_d;
  logic        page_cross_q, page_cross_d;

  logic [7:0]  add_sum;
  logic        add_carry;
  logic        need_fix;

  // One adder serves both OPHI and PHI: in both, the base low byte sits in lo_q.
  index_adder u_index_adder (
    .base  (lo_q),
    .index (idx_q),
    .sum   (add_sum),
    .carry (add_carry)
  );

  // Fix-up is taken on a real carry, or forced for store/RMW timing.
  always_comb begin
    need_fix = add_carry | (always_fix & is_indexed_abs(mode_q));
  end

  // Next-state and datapath updates for the address sequencer.
  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    idx_d        = idx_q;
    lo_d         = lo_q;
    ptr_d        = ptr_q;
    addr_d       = addr_q;
    carry_d      = carry_q;
    page_cross_d = page_cross_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          mode_d  = addr_mode_e'(mode);
          idx_d   = index_sel(addr_mode_e'(mode), x_index, y_index);
          state_d = OPLO;
        end
      end

      OPLO: begin
        if (db_valid) begin
          lo_d = db_in;
          case (mode_q)
            ZPX, ZPY: begin
              // Zero-page indexing wraps inside the page, never carries out.
              addr_d       = {ZP_BASE, 8'(db_in + idx_q)};
              page_cross_d = 1'b0;
              state_d      = DONE;
            end
            INDX: begin
              ptr_d   = 8'(db_in + idx_q);
              state_d = PLO;
            end
            INDY: begin
              ptr_d   = db_in;
              state_d = PLO;
            end
            default: state_d = OPHI;
          endcase
        end
      end

      OPHI: begin
        if (db_valid) begin
          addr_d  = {db_in, add_sum};
          carry_d = add_carry;
          if (need_fix) begin
            page_cross_d = add_carry;
            state_d      = FIX;
          end else begin
            page_cross_d = 1'b0;
            state_d      = DONE;
          end
        end
      end

      PLO: begin
        if (db_valid) begin
          lo_d    = db_in;
          ptr_d   = 8'(ptr_q + 8'd1);
          state_d = PHI;
        end
      end

      PHI: begin
        if (db_valid) begin
          if (mode_q == INDX) begin
            addr_d       = {db_in, lo_q};
            page_cross_d = 1'b0;
            state_d      = DONE;
          end else begin
            addr_d  = {db_in, add_sum};
            carry_d = add_carry;
            if (need_fix) begin
              page_cross_d = add_carry;
              state_d      = FIX;
            end else begin
              page_cross_d = 1'b0;
              state_d      = DONE;
            end
          end
        end
      end

      FIX: begin
        // Corrected high byte; $FF + carry wraps to $00.
        addr_d  = {8'(addr_q[15:8] + {7'b0, carry_q}), addr_q[7:0]};
        state_d = DONE;
      end

      DONE: begin
        page_cross_d = 1'b0;
        state_d      = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State registers; reset abandons any computation in flight.
  always_ff @(posedge clk or negedge resb) begin
    if (!resb) begin
      state_q      <= IDLE;
      mode_q       <= ZPX;
      idx_q        <= 8'h00;
      lo_q         <= 8'h00;
      ptr_q        <= 8'h00;
      addr_q       <= 16'h0000;
      carry_q      <= 1'b0;
      page_cross_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      idx_q        <= idx_d;
      lo_q         <= lo_d;
      ptr_q        <= ptr_d;
      addr_q       <= addr_d;
      carry_q      <= carry_d;
      page_cross_q <= page_cross_d;
    end
  end

  // All outputs decode directly from registered state.
  always_comb begin
    ptr_req    = (state_q == PLO) || (state_q == PHI);
    ptr_addr   = {ZP_BASE, ptr_q};
    busy       = (state_q != IDLE);
    addr_out   = addr_q;
    addr_valid = (state_q == DONE);
    page_cross = page_cross_q;
  end

endmodule

// File: doc/indexed_address_gen.md
Name: indexed_address_gen

Overview:
- Effective-address generator for the 65C02 core's indexed and indirect addressing modes.
- Consumes the X and Y index register address outputs and operand/pointer bytes from the data bus.
- Produces a 16-bit effective address, a page-cross flag and a zero-page pointer-fetch request to the bus sequencer.
- Sits between the index registers and the address bus mux.

Parameters:
- ZP_BASE, 8'h00, high byte used for all zero-page and pointer addresses.

Ports:
- clk  input  1  core clock; all state changes on rising edge.
- resb  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to begin an address computation; sampled only in IDLE.
- mode  input  3  addressing mode: 0 ZPX, 1 ZPY, 2 ABSX, 3 ABSY, 4 INDX (zp,X), 5 INDY (zp),Y, 6 ABS, 7 reserved (handled as ABS).
- always_fix  input  1  forces the fix-up cycle on indexed absolute and INDY modes (store/RMW timing).
- x_index  input  8  X register address output.
- y_index  input  8  Y register address output.
- db_in  input  8  operand or pointer byte.
- db_valid  input  1  db_in holds the byte the current state is waiting for.
- ptr_req  output  1  request a zero-page pointer byte read.
- ptr_addr  output  16  address of the pointer byte, {ZP_BASE, ptr}.
- busy  output  1  high in every state except IDLE.
- addr_out  output  16  effective address; held stable until the next DONE.
- addr_valid  output  1  one-cycle strobe, high in DONE.
- page_cross  output  1  high in FIX and DONE when the index add carried; cleared when leaving DONE.

Behaviour:
- Reset (resb low, asynchronous): state IDLE; addr_out=16'h0000; ptr_addr={ZP_BASE,8'h00}; all 1-bit outputs 0. Reset mid-operation abandons the computation with no strobe.
- IDLE:
  - On start, latch mode.
  - Latch the index value (x_index for ZPX/ABSX/INDX, y_index for ZPY/ABSY/INDY, 0 for ABS).
  - Go to OPLO.
  - Later changes to x_index or y_index do not affect the computation in progress.
- OPLO: wait for db_valid, then capture lo=db_in.
  - ZPX/ZPY: addr={ZP_BASE,(lo+idx) mod 256}; go to DONE. No carry into the high byte.
  - INDX: ptr=(lo+X) mod 256; go to PLO.
  - INDY: ptr=lo; go to PLO.
  - All others: go to OPHI.
- OPHI: wait for db_valid, then capture hi; compute the 9-bit sum={1'b0,lo}+idx.
  - If sum[8]=0 and always_fix=0: addr={hi,sum[7:0]}; go to DONE.
  - Otherwise: addr_out={hi,sum[7:0]} (the uncorrected dummy address); go to FIX.
- PLO:
  - ptr_req=1 and ptr_addr={ZP_BASE,ptr}.
  - On db_valid: base lo=db_in, ptr=(ptr+1) mod 256 (the wrap stays inside the zero page), go to PHI.
- PHI:
  - ptr_req=1.
  - On db_valid, INDX: addr={db_in,lo}; go to DONE.
  - On db_valid, INDY: same add and fix decision as OPHI, with hi=db_in.
- FIX: exactly one cycle.
  - hi=(hi+sum[8]) mod 256, so $FF carries into $00 and the address wraps to 16'h00xx.
  - page_cross=sum[8].
  - Go to DONE.
- DONE: addr_valid=1 for one cycle; go to IDLE. start is not accepted in DONE.
- start while busy is ignored. db_valid in IDLE, FIX or DONE is ignored.
- Minimum latency from start to addr_valid, with db_valid held high:
  - ZP modes: 2 cycles.
  - ABS modes, no fix: 3 cycles.
  - ABS modes with fix: 4 cycles.
  - INDX: 4 cycles.
  - INDY: 4 cycles, or 5 with fix.

Decomposition:
- Package cpu65_pkg holds:
  - typedef enum logic[2:0] addr_mode_e (ZPX..ABS, RSVD).
  - typedef enum agen_state_e {IDLE, OPLO, OPHI, PLO, PHI, FIX, DONE}.
  - Constant ZP_PAGE=8'h00.
- One sub-module, index_adder: 8-bit base plus 8-bit index gives an 8-bit sum and a carry. It is purely combinational and shared by OPHI and PHI.

Test Plan:
- ZPX, X=$10, operand $F8 -> addr_out=$0008, page_cross=0, addr_valid 2 cycles after start.
- ABSY, Y=$05, operands $F0,$12 -> $12F5 in 3 cycles. Same with always_fix=1 -> FIX cycle, $12F5, page_cross=0, 4 cycles.
- ABSX, X=$20, operands $F0,$FF -> dummy $FF10 visible in FIX, then $0010 with page_cross=1.
- INDX, X=$04, operand $FC -> ptr_addr $0000 then $0001; bytes $34,$12 -> $1234.
- INDY, Y=$80, operand $FF, pointer bytes $90 at $00FF and $20 at $0000 (zero-page wrap) -> $2110 with page_cross=1. Y changed mid-operation -> same result.
- Assert resb low during PHI -> outputs reset immediately with no addr_valid. Next start in ZPY mode completes normally. A start pulse while busy has no effect.
